// File: rtl/ro_deserializer.sv
// ro_deserializer: receive side of the 8-channel readout mux.
// It samples the shared serial event/polarity lines against the slot gray count.
// It recovers per-channel event/polarity bits.
// It queues every asserted event as {pol, chan} in a small FIFO with a valid/ready port.
// Optional build macro: RO_ERR_CNT_EN enables the saturating error counter err_cnt.
module ro_deserializer #(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned CH_W       = 3,
    parameter int unsigned ALIGN      = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk_master,
    input  logic            rstb,
    input  logic [N_CH-1:0] gray,
    input  logic            in_mux_eve,
    input  logic            in_mux_pol_eve,
    output logic [N_CH-1:0] ch_eve,
    output logic [N_CH-1:0] ch_pol,
    output logic [N_CH-1:0] ch_upd,
    output logic            ev_valid,
    output logic [CH_W:0]   ev_data,
    input  logic            ev_ready,
    output logic            ev_ovf,
    output logic            slot_err,
    output logic [7:0]      err_cnt
);
    localparam int unsigned PIPE_W = ALIGN + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = CH_W + 1;

    logic [N_CH-1:0]   gray_q;
    logic [N_CH-1:0]   gray_prev;
    logic [PIPE_W-1:0] eve_pipe;
    logic [PIPE_W-1:0] pol_pipe;
    logic              eve_s;
    logic              pol_s;

    logic [N_CH-1:0]   d_c;
    logic              slot_ok_c;
    logic              slot_bad_c;
    logic [CH_W-1:0]   slot_idx_c;

    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wr_nxt_c;
    logic [CNT_W-1:0]  rd_nxt_c;
    logic              full_c;
    logic              pop_c;
    logic              push_req_c;
    logic              push_c;
    logic              drop_c;
    logic [ENT_W-1:0]  push_data_c;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];

    assign eve_s = eve_pipe[ALIGN];
    assign pol_s = pol_pipe[ALIGN];
    assign d_c   = gray_q ^ gray_prev;

    // Input stage: one flop on gray, 1+ALIGN flops on the serial lines.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            gray_q    <= gray;
            gray_prev <= gray;
            eve_pipe  <= '0;
            pol_pipe  <= '0;
        end else begin
            gray_q    <= gray;
            gray_prev <= gray_q;
            eve_pipe  <= PIPE_W'({eve_pipe, in_mux_eve});
            pol_pipe  <= PIPE_W'({pol_pipe, in_mux_pol_eve});
        end
    end

    // Slot decode: a single toggling gray bit names the channel, several bits are an error.
    always_comb begin
        slot_ok_c  = 1'b0;
        slot_bad_c = 1'b0;
        slot_idx_c = '0;
        if (d_c != '0) begin
            if ((d_c & (d_c - N_CH'(1))) == '0) begin
                slot_ok_c = 1'b1;
            end else begin
                slot_bad_c = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_CH); i++) begin
            if (d_c[i]) begin
                slot_idx_c = CH_W'(i);
            end
        end
    end

    // Slot commit: update the decoded channel and flag illegal transitions.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            ch_eve   <= '0;
            ch_pol   <= '0;
            ch_upd   <= '0;
            slot_err <= 1'b0;
        end else begin
            ch_upd   <= slot_ok_c ? d_c : '0;
            slot_err <= slot_bad_c;
            if (slot_ok_c) begin
                ch_eve[slot_idx_c] <= eve_s;
                ch_pol[slot_idx_c] <= pol_s;
            end
        end
    end

    assign full_c      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_c       = ev_valid && ev_ready;
    assign push_req_c  = slot_ok_c && eve_s;
    assign push_c      = push_req_c && (!full_c || pop_c);
    assign drop_c      = push_req_c && full_c && !pop_c;
    assign push_data_c = {pol_s, slot_idx_c};
    assign wr_nxt_c    = wr_ptr + CNT_W'(push_c);
    assign rd_nxt_c    = rd_ptr + CNT_W'(pop_c);

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk_master) begin
        if (rstb && push_c) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data_c;
        end
    end

    // FIFO control: pointers, registered head/valid, sticky overflow.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_valid <= 1'b0;
            ev_data  <= '0;
            ev_ovf   <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt_c;
            rd_ptr   <= rd_nxt_c;
            ev_valid <= (wr_nxt_c != rd_nxt_c);
            if (push_c && (wr_ptr[PTR_W-1:0] == rd_nxt_c[PTR_W-1:0])) begin
                ev_data <= push_data_c;
            end else begin
                ev_data <= mem[rd_nxt_c[PTR_W-1:0]];
            end
            if (drop_c) begin
                ev_ovf <= 1'b1;
            end
        end
    end

`ifdef RO_ERR_CNT_EN
    // Saturating count of illegal slots and dropped events.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            err_cnt <= '0;
        end else if ((slot_bad_c || drop_c) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ro_deserializer.sv
// Bench for ro_deserializer: directed phases plus a random phase.
// All phases are checked every cycle against a history-based reference model.
module tb_ro_deserializer;
    localparam int unsigned N_CH  = 8;
    localparam int unsigned CH_W  = 3;
    localparam int unsigned ALIGN = 1;
    localparam int unsigned DEPTH = 8;
    localparam int AL   = int'(ALIGN);
    localparam int HMAX = 4096;
    localparam int PMAX = 1024;

    logic            clk_master = 1'b0;
    logic            rstb = 1'b0;
    logic [7:0]      gray = '0;
    logic            in_mux_eve = 1'b0;
    logic            in_mux_pol_eve = 1'b0;
    logic [7:0]      ch_eve, ch_pol, ch_upd;
    logic            ev_valid, ev_ready = 1'b0, ev_ovf, slot_err;
    logic [3:0]      ev_data;
    logic [7:0]      err_cnt;

    always #5 clk_master = ~clk_master;

    ro_deserializer #(.N_CH(N_CH), .CH_W(CH_W), .ALIGN(ALIGN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_master(clk_master), .rstb(rstb), .gray(gray),
        .in_mux_eve(in_mux_eve), .in_mux_pol_eve(in_mux_pol_eve),
        .ch_eve(ch_eve), .ch_pol(ch_pol), .ch_upd(ch_upd),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
        .ev_ovf(ev_ovf), .slot_err(slot_err), .err_cnt(err_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // What was driven at each clock edge.
    logic [7:0] g_h [HMAX];
    logic       e_h [HMAX];
    logic       p_h [HMAX];
    logic       r_h [HMAX];
    logic       s_h [HMAX];
    int         t = 0;
    int         reset_at = 0;

    // Reference state.
    logic [7:0] m_eve = '0, m_pol = '0, m_upd = '0;
    logic       m_err = 1'b0, m_ovf = 1'b0;
    int         m_cnt = 0;
    logic [3:0] q [$];

    // Phase plan: gray per cycle, data belonging to the transition into that cycle, ready.
    logic [7:0] pg [PMAX];
    logic       pe [PMAX];
    logic       pp [PMAX];
    logic       pr [PMAX];
    int         pn = 0;
    logic [7:0] cur_g = '0;
    logic [7:0] mux_eve = '0, mux_pol = '0;

    // Observations.
    int         upd_cnt [8];
    int         err_seen = 0;
    logic [3:0] popped [$];
    logic [3:0] exp_drain [8] = '{4'h9, 4'h0, 4'h2, 4'h0, 4'h9, 4'h0, 4'hB, 4'h0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gray8(input int k);
        logic [7:0] b;
        b = 8'(k);
        return b ^ (b >> 1);
    endfunction

    // Reference behaviour at edge k.
    function automatic void model_edge(input int k);
        int         m, idx, ones;
        logic [7:0] d;
        logic       es, ps, pop, push, full;
        if (!s_h[k]) begin
            m_eve = '0; m_pol = '0; m_upd = '0; m_err = 1'b0; m_ovf = 1'b0; m_cnt = 0;
            q.delete();
            reset_at = k;
            return;
        end
        pop  = r_h[k] && (q.size() != 0);
        push = 1'b0;
        m_upd = '0;
        m_err = 1'b0;
        idx = 0; es = 1'b0; ps = 1'b0;
        m = k - 1;
        if (m > reset_at) begin
            d = g_h[m] ^ g_h[m-1];
            ones = $countones(d);
            if (m - AL > reset_at) begin
                es = e_h[m-AL];
                ps = p_h[m-AL];
            end
            for (int i = 0; i < 8; i++) if (d[i]) idx = i;
            if (ones == 1) begin
                m_upd = d;
                m_eve[idx] = es;
                m_pol[idx] = ps;
                push = es;
            end else if (ones > 1) begin
                m_err = 1'b1;
                m_cnt++;
            end
        end
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (full && !pop) begin
                m_ovf = 1'b1;
                m_cnt++;
            end else begin
                q.push_back({ps, 3'(idx)});
            end
        end
        if (m_cnt > 255) m_cnt = 255;
    endfunction

    task automatic step(input logic [7:0] g, input logic e, input logic p, input logic r, input logic rs);
        logic [7:0] exp_cnt;
        gray = g; in_mux_eve = e; in_mux_pol_eve = p; ev_ready = r; rstb = rs;
        if (ev_valid === 1'b1 && r && rs) popped.push_back(ev_data);
        @(posedge clk_master);
        g_h[t] = g; e_h[t] = e; p_h[t] = p; r_h[t] = r; s_h[t] = rs;
        model_edge(t);
        t++;
        #1;
`ifdef RO_ERR_CNT_EN
        exp_cnt = 8'(m_cnt);
`else
        exp_cnt = 8'd0;
`endif
        check("ch_upd",   ch_upd,   m_upd);
        check("ch_eve",   ch_eve,   m_eve);
        check("ch_pol",   ch_pol,   m_pol);
        check("slot_err", slot_err, m_err);
        check("ev_valid", ev_valid, q.size() != 0);
        check("ev_ovf",   ev_ovf,   m_ovf);
        check("err_cnt",  err_cnt,  exp_cnt);
        if (q.size() != 0) check("ev_data", ev_data, q[0]);
        for (int i = 0; i < 8; i++) if (ch_upd[i] === 1'b1) upd_cnt[i]++;
        if (slot_err === 1'b1) err_seen++;
    endtask

    function automatic void add(input logic [7:0] g, input logic e, input logic p, input logic r);
        if (pn < PMAX) begin
            pg[pn] = g; pe[pn] = e; pp[pn] = p; pr[pn] = r;
            pn++;
        end
        cur_g = g;
    endfunction

    // Emulates the readout mux: the toggled bit selects which channel's bits ride the line.
    function automatic void add_mux(input logic [7:0] g, input logic r);
        logic [7:0] d;
        int idx;
        d = cur_g ^ g;
        idx = 0;
        for (int i = 0; i < 8; i++) if (d[i]) idx = i;
        if ($countones(d) == 1) add(g, mux_eve[idx], mux_pol[idx], r);
        else add(g, 1'b0, 1'b0, r);
    endfunction

    function automatic void plan_start(input logic r);
        pn = 0;
        for (int i = 0; i < AL; i++) add(cur_g, 1'b0, 1'b0, r);
    endfunction

    // The mux line leads gray by ALIGN cycles, so transition j's data is driven at cycle j-ALIGN.
    task automatic run_plan();
        for (int j = 0; j < pn; j++) begin
            if (j + AL < pn) step(pg[j], pe[j+AL], pp[j+AL], pr[j], 1'b1);
            else step(pg[j], 1'b0, 1'b0, pr[j], 1'b1);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 8; i++) upd_cnt[i] = 0;
        err_seen = 0;
        popped.delete();
    endtask

    task automatic do_reset();
        step(cur_g, 1'b0, 1'b0, 1'b0, 1'b0);
        step(cur_g, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] ng;
        int sum;
        clear_obs();

        // Reset state.
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_ch_eve", ch_eve, 8'h00);
        check("rst_ev_valid", ev_valid, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cur_g = 8'h00;

        // Full sweep with events only in channel-3 slots.
        clear_obs();
        mux_eve = 8'h08; mux_pol = 8'h08;
        plan_start(1'b1);
        for (int k = 1; k <= 256; k++) add_mux(gray8(k), 1'b1);
        for (int i = 0; i < 4; i++) add(cur_g, 1'b0, 1'b0, 1'b1);
        run_plan();
        check("sweep_upd3", upd_cnt[3], 16);
        check("sweep_pops", popped.size(), 16);
        sum = 0;
        foreach (popped[i]) if (popped[i] == 4'hB) sum++;
        check("sweep_pop_data", sum, 16);
        check("sweep_ch_eve", ch_eve, 8'h08);

        // Loopback of in_eve=FF / in_pol_eve=AA over a full sweep.
        clear_obs();
        mux_eve = 8'hFF; mux_pol = 8'hAA;
        plan_start(1'b1);
        for (int k = 1; k <= 256; k++) add_mux(gray8(k), 1'b1);
        for (int i = 0; i < 4; i++) add(cur_g, 1'b0, 1'b0, 1'b1);
        run_plan();
        check("loop_ch_eve", ch_eve, 8'hFF);
        check("loop_ch_pol", ch_pol, 8'hAA);
        check("loop_upd0", upd_cnt[0], 128);
        check("loop_upd7", upd_cnt[7], 2);
        check("loop_ovf", ev_ovf, 1'b0);

        // Ten events with ready low: FIFO fills, two drops.
        do_reset();
        clear_obs();
        mux_eve = 8'hFF; mux_pol = 8'h5A;
        plan_start(1'b0);
        for (int k = 1; k <= 10; k++) add_mux(gray8(k), 1'b0);
        for (int i = 0; i < 3; i++) add(cur_g, 1'b0, 1'b0, 1'b0);
        run_plan();
        check("ovf_valid", ev_valid, 1'b1);
        check("ovf_flag", ev_ovf, 1'b1);
`ifdef RO_ERR_CNT_EN
        check("ovf_err_cnt", err_cnt, 8'd2);
`endif
        check("ovf_head", ev_data, 4'h0);

        // Full FIFO: pop and push in the same cycle, nothing dropped.
        plan_start(1'b0);
        add_mux(gray8(11), 1'b0);
        add(cur_g, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add(cur_g, 1'b0, 1'b0, 1'b0);
        run_plan();
        check("fullpop_ovf", ev_ovf, 1'b1);
`ifdef RO_ERR_CNT_EN
        check("fullpop_err_cnt", err_cnt, 8'd2);
`endif
        check("fullpop_head", ev_data, 4'h9);

        // Drain in order.
        popped.delete();
        plan_start(1'b1);
        for (int i = 0; i < 10; i++) add(cur_g, 1'b0, 1'b0, 1'b1);
        run_plan();
        check("drain_len", popped.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < popped.size()) check("drain_entry", popped[i], exp_drain[i]);
        end
        check("drain_valid", ev_valid, 1'b0);

        // Illegal jump 00 -> 03, then a stalled counter.
        cur_g = 8'h00;
        do_reset();
        clear_obs();
        plan_start(1'b1);
        add(8'h03, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) add(cur_g, 1'b1, 1'b1, 1'b1);
        run_plan();
        check("jump_err_pulses", err_seen, 1);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += upd_cnt[i];
        check("jump_no_upd", sum, 0);
        check("jump_no_push", popped.size(), 0);
`ifdef RO_ERR_CNT_EN
        check("jump_err_cnt", err_cnt, 8'd1);
`endif

        // Reset with five queued events; gray moves on the reset cycle itself.
        mux_eve = 8'hFF; mux_pol = 8'hFF;
        plan_start(1'b0);
        for (int k = 3; k <= 7; k++) add_mux(gray8(k), 1'b0);
        for (int i = 0; i < 3; i++) add(cur_g, 1'b0, 1'b0, 1'b0);
        run_plan();
        check("pre_rst_valid", ev_valid, 1'b1);
        ng = cur_g ^ 8'h08;
        step(ng, 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_valid", ev_valid, 1'b0);
        check("post_rst_ch_eve", ch_eve, 8'h00);
        check("post_rst_ovf", ev_ovf, 1'b0);
        check("post_rst_err_cnt", err_cnt, 8'd0);
        step(ng, 1'b0, 1'b0, 1'b0, 1'b1);
        step(ng, 1'b0, 1'b0, 1'b0, 1'b1);
        check("post_rst_no_slot", ch_upd, 8'h00);
        cur_g = ng;

        // Random traffic: mostly legal steps, some stalls, some illegal jumps.
        plan_start(1'b1);
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            ng = cur_g;
            if (sel < 8) ng[$urandom_range(0, 7)] = ~ng[$urandom_range(0, 7)] ^ ng[$urandom_range(0, 7)];
            if (sel < 8) ng = cur_g ^ (8'h01 << $urandom_range(0, 7));
            else if (sel == 9) ng = cur_g ^ 8'h81;
            add(ng, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) add(cur_g, 1'b0, 1'b0, 1'b1);
        run_plan();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
